// File: rtl/matrix_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_engine_pkg
// Brief    : Shared constants and state type for the matrix register access
//            path (bus widths, register address window, arbiter FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package matrix_engine_pkg;

   // Register bus address width
   localparam int ADDR_W = 16;
   // Register data width: 4x4 elements of 16 bit
   localparam int DATA_W = 256;
   // addr[15:12] value that selects the matrix register unit
   localparam logic [3:0] REG_BASE_NIBBLE = 4'h4;

   // Access arbiter FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

endpackage : matrix_engine_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational NUM_REQ-wide request picker. Produces a one-hot
//            grant and the matching index from a request vector and the
//            index of the previous winner.
//            Build option ARB_FIXED_PRIO_EN: lowest valid index always wins
//            and the pointer is ignored. Default: round-robin, search starts
//            at pointer+1 and wraps from NUM_REQ-1 to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import matrix_engine_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_req
);

   assign any_req = |req;

`ifdef ARB_FIXED_PRIO_EN
   // The previous winner has no influence on a fixed-priority pick
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Fixed priority: scan from the top so the lowest valid index is written last
   always_comb begin
      grant_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant_idx = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] cand;

   // Round-robin: scan offsets from farthest to nearest so the requester just
   // after the pointer is written last and therefore wins
   always_comb begin
      grant_idx = '0;
      cand      = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (req[cand]) begin
            grant_idx = cand;
         end
      end
   end
`endif

   // One-hot form of the selected index, empty when nobody is requesting
   always_comb begin
      grant = '0;
      if (any_req) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_arbiter
// Brief    : Shares the single 256-bit matrix register between NUM_REQ
//            requesters. One transaction at a time: arbitrate in IDLE, strobe
//            the register in ISSUE, wait REG_READ_LAT cycles for read data,
//            then pulse the requester's rsp_valid in RESP.
//            Build option ARB_FIXED_PRIO_EN selects fixed priority
//            (lowest index wins) instead of the default round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module reg_access_arbiter
   import matrix_engine_pkg::*;
#(
   parameter int         NUM_REQ         = 3,
   parameter int         DATA_W          = matrix_engine_pkg::DATA_W,
   parameter int         ADDR_W          = matrix_engine_pkg::ADDR_W,
   parameter logic [3:0] REG_BASE_NIBBLE = matrix_engine_pkg::REG_BASE_NIBBLE,
   parameter int         REG_READ_LAT    = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      rsp_err,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      busy,
   output logic [ADDR_W-1:0]         addressBus,
   output logic [DATA_W-1:0]         inputDataBus,
   output logic                      writeToReg,
   output logic                      readFromReg,
   input  logic [DATA_W-1:0]         outputDataBus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = 2;
   localparam logic [CNT_W-1:0]   LAT_LOAD   = CNT_W'(REG_READ_LAT - 1);
   localparam logic [NUM_REQ-1:0] ONEHOT_LSB = NUM_REQ'(1);

   arb_state_t        state;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  cur_id;
   logic              cur_write;
   logic              cur_err;
   logic [CNT_W-1:0]  wait_cnt;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   win_idx;
   logic               any_req;
   logic [ADDR_W-1:0]  win_addr;
   logic [DATA_W-1:0]  win_wdata;
   logic               win_write;
   logic               win_in_window;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (win_idx),
      .any_req   (any_req)
   );

   // Winner's request fields and register-window decode
   always_comb begin
      win_addr      = req_addr[win_idx*ADDR_W +: ADDR_W];
      win_wdata     = req_wdata[win_idx*DATA_W +: DATA_W];
      win_write     = req_write[win_idx];
      win_in_window = (win_addr[ADDR_W-1 -: 4] == REG_BASE_NIBBLE);
   end

   // Accept handshake exists only in IDLE and is held off while reset is low
   always_comb begin
      req_ready = '0;
      if (state == IDLE && reset) begin
         req_ready = grant;
      end
   end

   // Transaction FSM; strobes and response pulses default low every cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ptr          <= IDX_W'(NUM_REQ - 1);
         cur_id       <= '0;
         cur_write    <= 1'b0;
         cur_err      <= 1'b0;
         wait_cnt     <= '0;
         rsp_valid    <= '0;
         rsp_err      <= 1'b0;
         rsp_rdata    <= '0;
         busy         <= 1'b0;
         addressBus   <= '0;
         inputDataBus <= '0;
         writeToReg   <= 1'b0;
         readFromReg  <= 1'b0;
      end else begin
         writeToReg  <= 1'b0;
         readFromReg <= 1'b0;
         rsp_valid   <= '0;
         rsp_err     <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  cur_id    <= win_idx;
                  cur_write <= win_write;
                  cur_err   <= ~win_in_window;
                  ptr       <= win_idx;
                  busy      <= 1'b1;
                  state     <= ISSUE;
                  // Out-of-window accesses leave the register buses untouched
                  if (win_in_window) begin
                     addressBus   <= win_addr;
                     inputDataBus <= win_wdata;
                     writeToReg   <= win_write;
                     readFromReg  <= ~win_write;
                  end
               end
            end
            ISSUE: begin
               if (cur_write || cur_err) begin
                  rsp_valid <= ONEHOT_LSB << cur_id;
                  rsp_err   <= cur_err;
                  state     <= RESP;
               end else begin
                  wait_cnt <= LAT_LOAD;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  rsp_rdata <= outputDataBus;
                  rsp_valid <= ONEHOT_LSB << cur_id;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : reg_access_arbiter
`default_nettype wire

// File: tb/tb_reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_access_arbiter
// Brief    : Directed self-checking bench for reg_access_arbiter with a small
//            behavioural model of the matrix register (read latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_access_arbiter;

   localparam int NR = 3;
   localparam int DW = 256;
   localparam int AW = 16;

   logic              clk;
   logic              reset;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_write;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     rsp_valid;
   logic              rsp_err;
   logic [DW-1:0]     rsp_rdata;
   logic              busy;
   logic [AW-1:0]     addressBus;
   logic [DW-1:0]     inputDataBus;
   logic              writeToReg;
   logic              readFromReg;
   logic [DW-1:0]     outputDataBus;

   logic [DW-1:0]     mreg;

   int checks = 0;
   int errors = 0;

   reg_access_arbiter #(
      .NUM_REQ      (NR),
      .DATA_W       (DW),
      .ADDR_W       (AW),
      .REG_READ_LAT (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_err       (rsp_err),
      .rsp_rdata     (rsp_rdata),
      .busy          (busy),
      .addressBus    (addressBus),
      .inputDataBus  (inputDataBus),
      .writeToReg    (writeToReg),
      .readFromReg   (readFromReg),
      .outputDataBus (outputDataBus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register model: write on strobe, read data valid the cycle after the strobe only
   always @(posedge clk) begin
      if (writeToReg) mreg <= inputDataBus;
      if (readFromReg) outputDataBus <= mreg;
      else             outputDataBus <= '0;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [DW-1:0] D1 = 256'h0017_002d_0003_0041_0005_0006_0107_0008_0a09_000a_000b_00cc_000d_000e_000f_0009;
   localparam logic [DW-1:0] DX = 256'hdead_beef_dead_beef_dead_beef_dead_beef_dead_beef_dead_beef_dead_beef_dead_beef;

   logic [DW-1:0] wd [NR];
   int            exp_g [6];
   logic [DW-1:0] lastdata;

   initial begin
      mreg      = '0;
      reset     = 1'b0;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      wd[0] = {16{16'h1111}};
      wd[1] = {16{16'h2222}};
      wd[2] = {16{16'h3333}};
`ifdef ARB_FIXED_PRIO_EN
      exp_g = '{0, 0, 0, 0, 0, 0};
`else
      exp_g = '{2, 0, 1, 2, 0, 1};
`endif
      lastdata = wd[exp_g[5]];

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_wr", writeToReg, 0);
      chk("rst_rd", readFromReg, 0);
      chk("rst_addr", addressBus, 0);
      reset = 1'b1;
      step();

      // Test 1: requester 0 writes D1 to 0x4000
      req_valid = 3'b001; req_write = 3'b001;
      req_addr[0*AW +: AW] = 16'h4000; req_wdata[0*DW +: DW] = D1;
      #1 chk("t1_ready", req_ready, 3'b001);
      step();
      req_valid = '0;
      chk("t1_wr", writeToReg, 1);
      chk("t1_rd", readFromReg, 0);
      chk("t1_addr", addressBus, 16'h4000);
      chk("t1_data", inputDataBus, D1);
      chk("t1_busy", busy, 1);
      chk("t1_early_rsp", rsp_valid, 0);
      step();
      chk("t1_rsp", rsp_valid, 3'b001);
      chk("t1_err", rsp_err, 0);
      chk("t1_wr_off", writeToReg, 0);
      step();
      chk("t1_idle", busy, 0);
      chk("t1_rsp_off", rsp_valid, 0);

      // Test 2: requester 1 reads 0x4000
      req_valid = 3'b010; req_write = 3'b000;
      req_addr[1*AW +: AW] = 16'h4000;
      #1 chk("t2_ready", req_ready, 3'b010);
      step();
      req_valid = '0;
      chk("t2_rd", readFromReg, 1);
      chk("t2_wr", writeToReg, 0);
      step();
      chk("t2_rd_off", readFromReg, 0);
      chk("t2_wait_rsp", rsp_valid, 0);
      step();
      chk("t2_rsp", rsp_valid, 3'b010);
      chk("t2_rdata", rsp_rdata, D1);
      chk("t2_err", rsp_err, 0);
      step();

      // Test 3: all requesters write continuously; grant order
      req_valid = 3'b111; req_write = 3'b111;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW]  = 16'h4000;
         req_wdata[i*DW +: DW] = wd[i];
      end
      #1;
      for (int t = 0; t < 6; t++) begin
         chk($sformatf("t3_grant%0d", t), req_ready, 3'b001 << exp_g[t]);
         step();
         chk($sformatf("t3_busy_ready%0d", t), req_ready, 0);
         chk($sformatf("t3_data%0d", t), inputDataBus, wd[exp_g[t]]);
         step();
         chk($sformatf("t3_rsp%0d", t), rsp_valid, 3'b001 << exp_g[t]);
         step();
      end
      req_valid = '0;

      // Test 4: requester 2 writes outside the window
      req_valid = 3'b100; req_write = 3'b100;
      req_addr[2*AW +: AW] = 16'h2000; req_wdata[2*DW +: DW] = DX;
      #1 chk("t4_ready", req_ready, 3'b100);
      step();
      req_valid = '0;
      chk("t4_no_wr", writeToReg, 0);
      chk("t4_no_rd", readFromReg, 0);
      chk("t4_addr_hold", addressBus, 16'h4000);
      step();
      chk("t4_rsp", rsp_valid, 3'b100);
      chk("t4_err", rsp_err, 1);
      chk("t4_rdata_hold", rsp_rdata, D1);
      step();

      // Requester 0 reads back; requester 1 arrives while busy
      req_valid = 3'b001; req_write = 3'b000;
      req_addr[0*AW +: AW] = 16'h4000; req_addr[1*AW +: AW] = 16'h4000;
      #1 chk("t4r_ready", req_ready, 3'b001);
      step();
      req_valid = 3'b010;
      #1 chk("t6_ready_issue", req_ready, 0);
      step();
      chk("t6_ready_wait", req_ready, 0);
      step();
      chk("t4r_rsp", rsp_valid, 3'b001);
      chk("t4r_rdata", rsp_rdata, lastdata);
      chk("t6_ready_resp", req_ready, 0);
      step();
      chk("t6_ready_idle", req_ready, 3'b010);
      step();
      chk("t5_rd", readFromReg, 1);
      step();

      // Test 5: reset during WAIT of the read
      reset = 1'b0;
      #1;
      chk("t5_rsp", rsp_valid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_rd_off", readFromReg, 0);
      chk("t5_addr", addressBus, 0);
      chk("t5_rdata", rsp_rdata, 0);
      chk("t5_ready", req_ready, 0);
      step();
      chk("t5_rsp_late", rsp_valid, 0);
      req_valid = 3'b111; req_write = 3'b111;
      reset = 1'b1;
      #1 chk("t5_first_grant", req_ready, 3'b001);
      step();
      req_valid = '0;
      chk("t5_wr", writeToReg, 1);
      chk("t5_wdata", inputDataBus, wd[0]);
      step();
      chk("t5_rsp_after", rsp_valid, 3'b001);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_reg_access_arbiter
`default_nettype wire
